aclk_alarm_ctrl: RTL and testbench
==================================

Name: aclk_alarm_ctrl

Overview:
Reads the stored alarm time and the running current time, and detects the minute at which they match. It then sequences the alarm through ringing, snooze, auto-timeout and stop. It sits between the alarm-time register and the alarm-clock top level, and drives the sound_alarm output to the speaker and display logic. All digit inputs are registered BCD values from other blocks.

Parameters:
RING_SECS, 60, seconds the alarm rings before auto-silencing (>=1)
SNOOZE_SECS, 300, seconds of silence per snooze (>=1)
MAX_SNOOZE, 3, snoozes allowed per alarm event (>=1)

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
one_second  input  1  single-cycle tick, once per second
alarm_button  input  1  alarm enable level; low cancels everything
stop_alarm  input  1  level/pulse; stops the current alarm event
snooze  input  1  single-cycle request; snoozes a ringing alarm
alarm_time_ms_hr, alarm_time_ls_hr, alarm_time_ms_min, alarm_time_ls_min  input  4 each  stored alarm time, BCD
current_time_ms_hr, current_time_ls_hr, current_time_ms_min, current_time_ls_min  input  4 each  running time, BCD
sound_alarm  output  1  speaker enable
snoozing  output  1  high while in SNOOZED
snooze_cnt  output  $clog2(MAX_SNOOZE+1)  snoozes consumed in this event

Behaviour:
- Reset and clock: reset is asynchronous, active-high; the block runs on clock.
- Reset values: state=IDLE; sound_alarm=0; snoozing=0; snooze_cnt=0; both timers=0; match_d=0.
- match (combinational) = alarm_button AND all four digit pairs equal. match_d is match registered.
- trigger = match AND NOT match_d.
  - Fires once per matching minute.
  - Also fires if alarm_button rises, or a new alarm is loaded, during an already-matching minute.
- FSM states: IDLE, RINGING, SNOOZED, DONE.
- Priority in every non-IDLE state: alarm_button low > stop_alarm > snooze > timer expiry.
- Any state with alarm_button low: go to IDLE next edge.
- IDLE:
  - On trigger, go to RINGING on the next edge.
  - sound_alarm rises on that same edge, so latency is 1 clock from the first matching cycle.
  - The ring timer is cleared on entry.
- RINGING:
  - sound_alarm=1.
  - The ring timer increments on each one_second.
  - On one_second with ring timer == RING_SECS-1, go to DONE.
  - stop_alarm: go to DONE.
  - snooze with snooze_cnt < MAX_SNOOZE: go to SNOOZED, snooze_cnt += 1, snooze timer cleared.
  - snooze with snooze_cnt == MAX_SNOOZE: ignored; stays RINGING and the ring timer continues.
- SNOOZED:
  - sound_alarm=0; snoozing=1.
  - The snooze timer increments on each one_second.
  - On one_second with snooze timer == SNOOZE_SECS-1, go to RINGING with the ring timer cleared.
  - stop_alarm: go to DONE.
  - snooze: ignored.
- DONE:
  - sound_alarm=0.
  - Stays until match==0 (alarm minute has passed or was disabled), then goes to IDLE.
  - This prevents re-trigger inside the same minute.
- snooze_cnt clears on entry to IDLE only.
- sound_alarm and snoozing are registered Moore outputs that update on the state-change edge.
- Timers:
  - Width $clog2(max(RING_SECS,SNOOZE_SECS)).
  - They never wrap; the expiry compare happens before increment.
  - A one_second arriving on the entry edge is not counted.
- Simultaneous events:
  - Trigger while in DONE is impossible, since match stays high.
  - A rising edge of match after DONE→IDLE behaves as a normal trigger.
  - Snooze and stop in the same cycle: stop wins.
  - Stop and timer expiry in the same cycle: DONE (same destination).
- Reset mid-ring or mid-snooze: immediate return to IDLE and all outputs 0.
  - If match remains high after reset release, match_d resets to 0, so the alarm re-triggers.
  - This is the required behaviour.

Decomposition:
- Shared package aclk_pkg:
  - Alarm FSM state enum (IDLE, RINGING, SNOOZED, DONE).
  - BCD digit type (4-bit).
  - Default RING_SECS / SNOOZE_SECS / MAX_SNOOZE constants.
- One sub-module: aclk_sec_timer, a clearable up-counter on one_second with an expiry flag at LIMIT-1.
  - Parameter: LIMIT.
  - Instantiated twice: ring timer and snooze timer.

Test Plan:
- Basic ring: bench uses RING_SECS=4. Alarm 07:30, current steps 07:29→07:30 with alarm_button=1 → sound_alarm=1 one clock later; drops to 0 after the 4th one_second tick; stays 0 through 07:30; IDLE at 07:31.
- Stop: while ringing, pulse stop_alarm → sound_alarm=0 next edge; no re-ring while current stays 07:30; a new alarm 07:31 rings normally.
- Snooze: bench uses SNOOZE_SECS=3, MAX_SNOOZE=2. Snooze at ring → snoozing=1, snooze_cnt=1, silent 3 ticks, then rings. Second snooze → snooze_cnt=2. Third snooze ignored; sound stays 1 until RING_SECS expires.
- Priority: stop_alarm and snooze in the same cycle while ringing → DONE, snooze_cnt unchanged. alarm_button dropped during SNOOZED → IDLE, snooze_cnt=0.
- Enable mid-minute: current=alarm=12:00 with alarm_button=0, then raise alarm_button → rings next clock.
- Async reset while ringing at 12:00 → sound_alarm=0 immediately. After release, with match still high → rings again one clock later.

Source files
------------

// File: rtl/aclk_pkg.sv
// Shared types and defaults for the alarm controller: FSM states, BCD digit type,
// default timing constants and the timer width helper.
package aclk_pkg;

    typedef enum logic [1:0] {StIdle, StRinging, StSnoozed, StDone} alarm_state_e;

    typedef logic [3:0] bcd_t;

    localparam int unsigned DefRingSecs   = 60;
    localparam int unsigned DefSnoozeSecs = 300;
    localparam int unsigned DefMaxSnooze  = 3;

    // Shared timer width; never narrower than one bit, even when both limits are 1.
    function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/aclk_sec_timer.sv
// Clearable seconds up-counter; flags expiry at LIMIT-1 and saturates there.
module aclk_sec_timer #(
    parameter int unsigned LIMIT = 60,
    parameter int unsigned WIDTH = 6
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    input  logic one_second,
    output logic expired
);

    localparam logic [WIDTH-1:0] LastCount = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] count_q;

    // Clear wins over a tick on the same edge, so an entry-edge tick is not counted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && one_second && !expired) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired = (count_q == LastCount);

endmodule

// File: rtl/aclk_alarm_ctrl.sv
// Alarm sequencer: detects the matching minute, then runs ring / snooze / timeout / stop.
module aclk_alarm_ctrl
    import aclk_pkg::*;
#(
    parameter int unsigned RING_SECS   = DefRingSecs,
    parameter int unsigned SNOOZE_SECS = DefSnoozeSecs,
    parameter int unsigned MAX_SNOOZE  = DefMaxSnooze
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            one_second,
    input  logic                            alarm_button,
    input  logic                            stop_alarm,
    input  logic                            snooze,
    input  bcd_t                            alarm_time_ms_hr,
    input  bcd_t                            alarm_time_ls_hr,
    input  bcd_t                            alarm_time_ms_min,
    input  bcd_t                            alarm_time_ls_min,
    input  bcd_t                            current_time_ms_hr,
    input  bcd_t                            current_time_ls_hr,
    input  bcd_t                            current_time_ms_min,
    input  bcd_t                            current_time_ls_min,
    output logic                            sound_alarm,
    output logic                            snoozing,
    output logic [$clog2(MAX_SNOOZE+1)-1:0] snooze_cnt
);

    localparam int unsigned TimerW = timer_width(RING_SECS, SNOOZE_SECS);
    localparam int unsigned CntW   = $clog2(MAX_SNOOZE + 1);

    alarm_state_e    state_q, state_d;
    logic [CntW-1:0] snooze_cnt_q, snooze_cnt_d;
    logic            match, match_q, trigger;
    logic            ring_clear, ring_expired, snz_clear, snz_expired;
    logic            sound_q, snoozing_q;

    assign match = alarm_button
                && (alarm_time_ms_hr  == current_time_ms_hr)
                && (alarm_time_ls_hr  == current_time_ls_hr)
                && (alarm_time_ms_min == current_time_ms_min)
                && (alarm_time_ls_min == current_time_ls_min);

    assign trigger = match && !match_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (trigger) state_d = StRinging;
            end
            StRinging: begin
                if (!alarm_button)                                    state_d = StIdle;
                else if (stop_alarm)                                  state_d = StDone;
                else if (snooze && (snooze_cnt_q < CntW'(MAX_SNOOZE))) state_d = StSnoozed;
                else if (one_second && ring_expired)                  state_d = StDone;
            end
            StSnoozed: begin
                if (!alarm_button)                  state_d = StIdle;
                else if (stop_alarm)                state_d = StDone;
                else if (one_second && snz_expired) state_d = StRinging;
            end
            StDone: begin
                // Hold until the matching minute is over so it cannot re-trigger.
                if (!alarm_button || !match) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        snooze_cnt_d = snooze_cnt_q;
        if (state_d == StIdle && state_q != StIdle) begin
            snooze_cnt_d = '0;
        end else if (state_q == StRinging && state_d == StSnoozed) begin
            snooze_cnt_d = snooze_cnt_q + 1'b1;
        end
    end

    assign ring_clear = (state_d == StRinging) && (state_q != StRinging);
    assign snz_clear  = (state_d == StSnoozed) && (state_q != StSnoozed);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            match_q      <= 1'b0;
            snooze_cnt_q <= '0;
            sound_q      <= 1'b0;
            snoozing_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            match_q      <= match;
            snooze_cnt_q <= snooze_cnt_d;
            sound_q      <= (state_d == StRinging);
            snoozing_q   <= (state_d == StSnoozed);
        end
    end

    aclk_sec_timer #(
        .LIMIT (RING_SECS),
        .WIDTH (TimerW)
    ) u_ring_timer (
        .clock      (clock),
        .reset      (reset),
        .clear      (ring_clear),
        .enable     (state_q == StRinging),
        .one_second (one_second),
        .expired    (ring_expired)
    );

    aclk_sec_timer #(
        .LIMIT (SNOOZE_SECS),
        .WIDTH (TimerW)
    ) u_snooze_timer (
        .clock      (clock),
        .reset      (reset),
        .clear      (snz_clear),
        .enable     (state_q == StSnoozed),
        .one_second (one_second),
        .expired    (snz_expired)
    );

    assign sound_alarm = sound_q;
    assign snoozing    = snoozing_q;
    assign snooze_cnt  = snooze_cnt_q;

endmodule

// File: tb/tb_aclk_alarm_ctrl.sv
// Scripted bench for aclk_alarm_ctrl; expected {sound, snoozing, snooze_cnt} go through a queue.
module tb_aclk_alarm_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       one_second = 1'b0;
    logic       alarm_button = 1'b1;
    logic       stop_alarm = 1'b0;
    logic       snooze = 1'b0;
    logic [3:0] a_mh = 4'd0, a_lh = 4'd7, a_mm = 4'd3, a_lm = 4'd0;
    logic [3:0] c_mh = 4'd0, c_lh = 4'd7, c_mm = 4'd2, c_lm = 4'd9;
    logic       sound_alarm, snoozing;
    logic [1:0] snooze_cnt;

    int checks = 0;
    int failures = 0;

    logic [3:0] exp_q[$];
    string      tag_q[$];

    always #5 clock = ~clock;

    aclk_alarm_ctrl #(
        .RING_SECS   (4),
        .SNOOZE_SECS (3),
        .MAX_SNOOZE  (2)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .one_second          (one_second),
        .alarm_button        (alarm_button),
        .stop_alarm          (stop_alarm),
        .snooze              (snooze),
        .alarm_time_ms_hr    (a_mh),
        .alarm_time_ls_hr    (a_lh),
        .alarm_time_ms_min   (a_mm),
        .alarm_time_ls_min   (a_lm),
        .current_time_ms_hr  (c_mh),
        .current_time_ls_hr  (c_lh),
        .current_time_ms_min (c_mm),
        .current_time_ls_min (c_lm),
        .sound_alarm         (sound_alarm),
        .snoozing            (snoozing),
        .snooze_cnt          (snooze_cnt)
    );

    task automatic check_eq(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got {snd,snz,cnt}=%b expected %b", tag, obs, exp);
        end
    endtask

    task automatic compare_next();
        check_eq(tag_q.pop_front(), {sound_alarm, snoozing, snooze_cnt}, exp_q.pop_front());
    endtask

    // One clock with optional single-cycle pulses; outputs sampled 1 time unit after the edge.
    task automatic cyc(input logic sec, input logic stp, input logic snz,
                       input logic [3:0] exp, input string tag);
        one_second = sec;
        stop_alarm = stp;
        snooze     = snz;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(posedge clock);
        #1;
        one_second = 1'b0;
        stop_alarm = 1'b0;
        snooze     = 1'b0;
        compare_next();
    endtask

    task automatic set_alarm(input logic [3:0] mh, lh, mm, lm);
        a_mh = mh; a_lh = lh; a_mm = mm; a_lm = lm;
    endtask

    task automatic set_cur(input logic [3:0] mh, lh, mm, lm);
        c_mh = mh; c_lh = lh; c_mm = mm; c_lm = lm;
    endtask

    initial begin
        // Reset state
        #12;
        exp_q.push_back(4'b0000); tag_q.push_back("reset_state");
        compare_next();
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;

        // Basic ring at 07:30
        cyc(0, 0, 0, 4'b0000, "idle_0729");
        set_cur(0, 7, 3, 0);
        cyc(0, 0, 0, 4'b1000, "ring_start");
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 4'b1000, "ring_tick");
        cyc(1, 0, 0, 4'b0000, "ring_timeout");
        cyc(0, 0, 0, 4'b0000, "done_hold");
        cyc(1, 0, 0, 4'b0000, "done_hold_tick");
        set_cur(0, 7, 3, 1);
        cyc(0, 0, 0, 4'b0000, "idle_0731");

        // Stop
        set_cur(0, 7, 3, 0);
        cyc(0, 0, 0, 4'b1000, "stop_ring");
        cyc(1, 0, 0, 4'b1000, "stop_ring_tick");
        cyc(0, 1, 0, 4'b0000, "stop_silence");
        for (int i = 0; i < 2; i++) cyc(0, 0, 0, 4'b0000, "stop_no_rering");
        set_cur(0, 7, 3, 1);
        cyc(0, 0, 0, 4'b0000, "stop_to_idle");
        set_alarm(0, 7, 3, 1);
        cyc(0, 0, 0, 4'b1000, "new_alarm_ring");
        cyc(0, 1, 0, 4'b0000, "new_alarm_stop");
        set_cur(0, 7, 3, 2);
        cyc(0, 0, 0, 4'b0000, "idle_0732");

        // Snooze up to the limit, third snooze ignored
        set_alarm(0, 8, 0, 0);
        set_cur(0, 8, 0, 0);
        cyc(0, 0, 0, 4'b1000, "snz_ring");
        cyc(0, 0, 1, 4'b0101, "snz_first");
        cyc(1, 0, 0, 4'b0101, "snz1_tick1");
        cyc(0, 0, 1, 4'b0101, "snz1_ignored");
        cyc(1, 0, 0, 4'b0101, "snz1_tick2");
        cyc(1, 0, 0, 4'b1001, "snz1_rering");
        cyc(0, 0, 1, 4'b0110, "snz_second");
        cyc(1, 0, 0, 4'b0110, "snz2_tick1");
        cyc(1, 0, 0, 4'b0110, "snz2_tick2");
        cyc(1, 0, 0, 4'b1010, "snz2_rering");
        cyc(0, 0, 1, 4'b1010, "snz_third_ignored");
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 4'b1010, "snz_max_ring_tick");
        cyc(1, 0, 0, 4'b0010, "snz_max_timeout");
        set_cur(0, 8, 0, 1);
        cyc(0, 0, 0, 4'b0000, "snz_idle_clears_cnt");

        // Priority: stop beats snooze; button low beats everything
        set_alarm(0, 8, 0, 1);
        cyc(0, 0, 0, 4'b1000, "prio_ring");
        cyc(0, 0, 1, 4'b0101, "prio_snooze");
        for (int i = 0; i < 2; i++) cyc(1, 0, 0, 4'b0101, "prio_snz_tick");
        cyc(1, 0, 0, 4'b1001, "prio_rering");
        cyc(0, 1, 1, 4'b0001, "prio_stop_wins");
        set_cur(0, 8, 0, 2);
        cyc(0, 0, 0, 4'b0000, "prio_idle");
        set_alarm(0, 8, 0, 2);
        cyc(0, 0, 0, 4'b1000, "btn_ring");
        cyc(0, 0, 1, 4'b0101, "btn_snooze");
        cyc(1, 0, 0, 4'b0101, "btn_snz_tick");
        alarm_button = 1'b0;
        cyc(0, 0, 0, 4'b0000, "btn_low_idle");
        cyc(0, 0, 0, 4'b0000, "btn_low_hold");

        // Enable during an already-matching minute
        set_alarm(1, 2, 0, 0);
        set_cur(1, 2, 0, 0);
        cyc(0, 0, 0, 4'b0000, "en_off_match");
        alarm_button = 1'b1;
        cyc(0, 0, 0, 4'b1000, "en_rise_ring");

        // Asynchronous reset mid-ring, re-trigger after release
        reset = 1'b1;
        #2;
        exp_q.push_back(4'b0000); tag_q.push_back("async_reset");
        compare_next();
        @(negedge clock);
        reset = 1'b0;
        cyc(0, 0, 0, 4'b1000, "reset_retrigger");
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 4'b1000, "retrig_tick");
        cyc(1, 1, 0, 4'b0000, "stop_and_expiry");
        set_cur(1, 2, 0, 1);
        cyc(0, 0, 0, 4'b0000, "final_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
